// File: rtl/fnd_scan_mux.sv
// fnd_scan_mux: time-multiplexed digit scanner for the multi-digit FND display.
// Selects one channel per scan slot, drives an active-low one-hot anode and the
// registered digit value. Channel data is snapshotted once per frame.
// Optional build macro FND_SCAN_DIM_EN adds a 3-bit 'bright' input that shortens
// the anode on-time within each slot.
module fnd_scan_mux #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_CH*DATA_W-1:0]  din,
    input  logic [NUM_CH-1:0]         blank_mask,
`ifdef FND_SCAN_DIM_EN
    input  logic [2:0]                bright,
`endif
    output logic [$clog2(NUM_CH)-1:0] sel,
    output logic [DATA_W-1:0]         dout,
    output logic [NUM_CH-1:0]         digit_an,
    output logic                      scan_tick
);

    localparam int unsigned SEL_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
`ifdef FND_SCAN_DIM_EN
    localparam int unsigned PROD_W = CNT_W + 4;
`endif

    // ST_IDLE: not yet primed since reset; ST_SCAN: scanning frames
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [SEL_W-1:0]               sel_q, sel_d;
    logic [DATA_W-1:0]              dout_q, dout_d;
    logic [NUM_CH-1:0]              an_q, an_d;
    logic                           tick_q, tick_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  snap_q, snap_d;
    logic                           frame_start;
    logic                           dim_on;
`ifdef FND_SCAN_DIM_EN
    logic [PROD_W-1:0]              on_prod;
    logic [PROD_W-1:0]              on_lim;
`endif

    // State, divider, channel select, snapshot and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            dout_q  <= '0;
            an_q    <= '1;
            tick_q  <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state: priming, slot advance, frame snapshot and anode decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        tick_d      = 1'b0;
        snap_d      = snap_q;
        frame_start = 1'b0;
        an_d        = '1;
        dim_on      = 1'b1;
`ifdef FND_SCAN_DIM_EN
        on_prod     = '0;
        on_lim      = '0;
`endif

        if (en) begin
            if (state_q == ST_IDLE) begin
                // first enabled cycle: load the frame, stay on slot 0, no tick
                state_d     = ST_SCAN;
                frame_start = 1'b1;
            end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (sel_q == SEL_W'(NUM_CH - 1)) begin
                    sel_d       = '0;
                    frame_start = 1'b1;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (frame_start) begin
            snap_d = din;
        end

        // snapshot loads on this same edge, so lane 0 comes straight from din
        dout_d = frame_start ? din[DATA_W-1:0] : snap_q[sel_d];

`ifdef FND_SCAN_DIM_EN
        on_prod = (PROD_W'(bright) + PROD_W'(1)) * PROD_W'(SCAN_DIV);
        on_lim  = on_prod >> 3;
        dim_on  = (PROD_W'(cnt_d) < on_lim);
`endif

        if (en && (state_d == ST_SCAN) && !blank_mask[sel_d] && dim_on) begin
            an_d[sel_d] = 1'b0;
        end
    end

    assign sel       = sel_q;
    assign dout      = dout_q;
    assign digit_an  = an_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_mux.sv
// Testbench for fnd_scan_mux: directed vector table, hand-written corner
// sequences and randomized stimulus against a slot-position reference model.
module tb_fnd_scan_mux;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] din;
    logic [3:0]  blank_mask;
    logic [1:0]  sel;
    logic [3:0]  dout;
    logic [3:0]  digit_an;
    logic        scan_tick;
`ifdef FND_SCAN_DIM_EN
    logic [2:0]  bright = 3'd7;
`endif

    fnd_scan_mux #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .din        (din),
        .blank_mask (blank_mask),
`ifdef FND_SCAN_DIM_EN
        .bright     (bright),
`endif
        .sel        (sel),
        .dout       (dout),
        .digit_an   (digit_an),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: position counts enabled cycles since priming; slot,
    // channel and frame all follow from integer division of that position.
    bit          m_primed;
    int          m_pos;
    logic [15:0] m_frame;
    logic        m_tick;
    logic        m_en_l;
    logic [3:0]  m_blank_l;

    task automatic model_reset();
        m_primed  = 0;
        m_pos     = 0;
        m_frame   = '0;
        m_tick    = 1'b0;
        m_en_l    = 1'b0;
        m_blank_l = '0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            m_tick = 1'b0;
            if (en) begin
                if (!m_primed) begin
                    m_primed = 1;
                    m_pos    = 0;
                    m_frame  = din;
                end else begin
                    m_pos++;
                    if (m_pos % SCAN_DIV == 0) begin
                        m_tick = 1'b1;
                        if ((m_pos / SCAN_DIV) % NUM_CH == 0) m_frame = din;
                    end
                end
            end
            m_en_l    = en;
            m_blank_l = blank_mask;
        end
    endtask

    function automatic int exp_sel();
        return m_primed ? (m_pos / SCAN_DIV) % NUM_CH : 0;
    endfunction

    function automatic int exp_dout();
        int s = exp_sel();
        return m_primed ? int'((m_frame >> (s * DATA_W)) & 16'h000F) : 0;
    endfunction

    function automatic int exp_an();
        int s = exp_sel();
        logic [3:0] a = 4'hF;
        if (m_en_l && m_primed && !m_blank_l[s]) a[s] = 1'b0;
        return int'(a);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".sel"},  int'(sel),       exp_sel());
        chk({tag, ".dout"}, int'(dout),      exp_dout());
        chk({tag, ".an"},   int'(digit_an),  exp_an());
        chk({tag, ".tick"}, int'(scan_tick), int'(m_tick));
    endtask

    task automatic check_out(input string tag, input int s, input int d, input int a, input int t);
        chk({tag, ".sel"},  int'(sel),       s);
        chk({tag, ".dout"}, int'(dout),      d);
        chk({tag, ".an"},   int'(digit_an),  a);
        chk({tag, ".tick"}, int'(scan_tick), t);
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs read 1 later
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        int          n;
        logic        en;
        logic [15:0] din;
        logic [3:0]  blank;
        int          sel;
        int          dout;
        int          an;
        int          tick;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // scan from reset, mid-frame din change, blanked slot 2 then unblanked
        tbl[0]  = '{4, 1'b1, 16'h4321, 4'h0, 0, 1, 4'hE, 0};
        tbl[1]  = '{1, 1'b1, 16'h4321, 4'h0, 1, 2, 4'hD, 1};
        tbl[2]  = '{3, 1'b1, 16'h8765, 4'h4, 1, 2, 4'hD, 0};
        tbl[3]  = '{1, 1'b1, 16'h8765, 4'h4, 2, 3, 4'hF, 1};
        tbl[4]  = '{3, 1'b1, 16'h8765, 4'h4, 2, 3, 4'hF, 0};
        tbl[5]  = '{1, 1'b1, 16'h8765, 4'h4, 3, 4, 4'h7, 1};
        tbl[6]  = '{3, 1'b1, 16'h8765, 4'h4, 3, 4, 4'h7, 0};
        tbl[7]  = '{1, 1'b1, 16'h8765, 4'h4, 0, 5, 4'hE, 1};
        tbl[8]  = '{3, 1'b1, 16'h8765, 4'h4, 0, 5, 4'hE, 0};
        tbl[9]  = '{1, 1'b1, 16'h8765, 4'h4, 1, 6, 4'hD, 1};
        tbl[10] = '{3, 1'b1, 16'h8765, 4'h4, 1, 6, 4'hD, 0};
        tbl[11] = '{1, 1'b1, 16'h8765, 4'h4, 2, 7, 4'hF, 1};
        tbl[12] = '{3, 1'b1, 16'h8765, 4'h0, 2, 7, 4'hB, 0};
        tbl[13] = '{1, 1'b1, 16'h8765, 4'h0, 3, 8, 4'h7, 1};

        reset      = 1'b1;
        en         = 1'b0;
        din        = '0;
        blank_mask = '0;
        model_reset();
        step();
        step();
        check_out("reset", 0, 0, 4'hF, 0);
        reset = 1'b0;
        step();
        check_out("unprimed_idle", 0, 0, 4'hF, 0);

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                en         = tbl[i].en;
                din        = tbl[i].din;
                blank_mask = tbl[i].blank;
                step();
                check_out($sformatf("vec%0d_%0d", i, r),
                          tbl[i].sel, tbl[i].dout, tbl[i].an, tbl[i].tick);
            end
        end

        // en dropped at cnt=2 of slot 1 for 10 cycles, then resumed
        reset = 1'b1;
        model_reset();
        step();
        reset      = 1'b0;
        en         = 1'b1;
        din        = 16'h4321;
        blank_mask = '0;
        repeat (7) step();
        check_out("pre_pause", 1, 2, 4'hD, 0);
        en = 1'b0;
        step();
        check_out("pause_first", 1, 2, 4'hF, 0);
        for (int k = 0; k < 9; k++) begin
            step();
            check_out($sformatf("pause%0d", k), 1, 2, 4'hF, 0);
        end
        en = 1'b1;
        step();
        check_out("resume_cnt3", 1, 2, 4'hD, 0);
        step();
        check_out("resume_tick", 2, 3, 4'hB, 1);

        // async reset in the middle of slot 3, then re-prime
        repeat (5) step();
        check_out("slot3", 3, 4, 4'h7, 0);
        reset = 1'b1;
        model_reset();
        #1;
        check_out("async_reset", 0, 0, 4'hF, 0);
        step();
        reset = 1'b0;
        din   = 16'hA9CB;
        step();
        check_out("reprime", 0, 4'hB, 4'hE, 0);
        repeat (3) step();
        check_out("reprime_hold", 0, 4'hB, 4'hE, 0);
        step();
        check_out("reprime_tick", 1, 4'hC, 4'hD, 1);

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            en = (($urandom % 10) != 0);
            if (($urandom % 6) == 0) din = 16'($urandom);
            if (($urandom % 8) == 0) blank_mask = 4'($urandom);
            if (($urandom % 150) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_model($sformatf("rnd_rst%0d", c));
                step();
                reset = 1'b0;
            end
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
